// File: rtl/ahb_wb_bridge_pkg.sv
// Shared encodings and FSM state type for the AHB-Lite to Wishbone bridge.
package ahb_wb_bridge_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HS_BYTE = 3'd0,
      HS_HALF = 3'd1,
      HS_WORD = 3'd2
   } hsize_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_READ,
      ST_WRITE,
      ST_RMW_READ,
      ST_RMW_MERGE,
      ST_ERR1,
      ST_ERR2
   } state_t;

   function automatic logic trans_active(logic [1:0] t);
      return (t == HT_NONSEQ) || (t == HT_SEQ);
   endfunction

   function automatic logic is_sub_word(logic [2:0] size);
      return size < HS_WORD;
   endfunction

endpackage

// File: rtl/ahb_wb_bridge_if.sv
// AHB-Lite slave-side and Wishbone classic master-side bundles.
interface ahb_lite_if;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        hexcl;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic        hexokay;

   modport master (
      output haddr, htrans, hwrite, hsize, hexcl, hwdata,
      input  hrdata, hready, hresp, hexokay
   );

   modport slave (
      input  haddr, htrans, hwrite, hsize, hexcl, hwdata,
      output hrdata, hready, hresp, hexokay
   );
endinterface

interface wb_classic_if;
   logic        core_cyc;
   logic        core_stb;
   logic        core_we;
   logic [31:0] core_addr;
   logic [31:0] core_data_out;
   logic [31:0] core_data_in;
   logic        core_ack;
   logic [3:0]  core_sel;

   modport master (
      output core_cyc, core_stb, core_we, core_addr,
      output core_data_out, core_sel,
      input  core_data_in, core_ack
   );

   modport slave (
      input  core_cyc, core_stb, core_we, core_addr,
      input  core_data_out, core_sel,
      output core_data_in, core_ack
   );
endinterface

// File: rtl/ahb_wb_lane_merge.sv
// Byte-lane mask from size/offset and merge of new lanes over an old word.
module ahb_wb_lane_merge
   import ahb_wb_bridge_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr,
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   output logic [3:0]  mask,
   output logic [31:0] merged
);

   always_comb begin
      mask = 4'hF;
      unique case (1'b1)
         (size == HS_BYTE): mask = 4'b0001 << addr;
         (size == HS_HALF): mask = addr[1] ? 4'b1100 : 4'b0011;
         default:           mask = 4'hF;
      endcase
   end

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge with optional
// read-modify-write for sub-word stores, exclusive monitor and timeout.
module ahb_wb_bridge
   import ahb_wb_bridge_pkg::*;
#(
   parameter int          RMW_ENABLE     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic      clk_core,
   input  logic      rst_core,
   ahb_lite_if.slave ahb,
   wb_classic_if.master wb
);

   localparam int CW =
      (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TMAX =
      (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   state_t state;
   state_t state_d;

   logic [31:0]   addr_q;
   logic [2:0]    size_q;
   logic          excl_q;
   logic [31:0]   wdata_q;
   logic [31:0]   old_q;
   logic          resv_v;
   logic [29:0]   resv_a;
   logic          excl_pass;
   logic [CW-1:0] cnt;

   logic        cyc_d;
   logic        stb_d;
   logic        we_d;
   logic [3:0]  sel_d;
   logic [31:0] dout_d;

   logic        ack_v;
   logic        tmo;
   logic        resv_hit;
   logic        accept;
   logic [3:0]  lane_mask;
   logic [31:0] merged;

   assign ack_v    = wb.core_ack & wb.core_cyc;
   assign tmo      = (TIMEOUT_CYCLES != 0) && wb.core_stb
                     && (cnt == TMAX);
   assign resv_hit = resv_v && (resv_a == addr_q[31:2]);
   assign accept   = (state == ST_IDLE) && trans_active(ahb.htrans);

   assign ahb.hready = (state == ST_IDLE) || (state == ST_ERR2);
   assign ahb.hresp  = (state == ST_ERR1) || (state == ST_ERR2);

   ahb_wb_lane_merge u_merge (
      .size     (size_q),
      .addr     (addr_q[1:0]),
      .old_word (old_q),
      .new_word (wdata_q),
      .mask     (lane_mask),
      .merged   (merged)
   );

   always_ff @(posedge clk_core) begin
      if (rst_core) state <= ST_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = 4'h0;
      dout_d  = wb.core_data_out;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (ahb.hwrite) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d = ST_READ;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  sel_d   = 4'hF;
               end
            end
         end
         ST_WDATA: begin
            if (excl_q && !resv_hit) begin
               state_d = ST_IDLE;
            end else if (RMW_ENABLE != 0 && is_sub_word(size_q)) begin
               state_d = ST_RMW_READ;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               sel_d   = 4'hF;
            end else begin
               state_d = ST_WRITE;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = lane_mask;
               dout_d  = ahb.hwdata;
            end
         end
         ST_READ, ST_RMW_READ, ST_WRITE: begin
            if (ack_v) begin
               state_d = (state == ST_RMW_READ) ? ST_RMW_MERGE
                                                : ST_IDLE;
            end else if (tmo) begin
               state_d = ST_ERR1;
            end else begin
               cyc_d = wb.core_cyc;
               stb_d = wb.core_stb;
               we_d  = wb.core_we;
               sel_d = wb.core_sel;
            end
         end
         ST_RMW_MERGE: begin
            state_d = ST_WRITE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 4'hF;
            dout_d  = merged;
         end
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         wb.core_cyc      <= 1'b0;
         wb.core_stb      <= 1'b0;
         wb.core_we       <= 1'b0;
         wb.core_sel      <= 4'h0;
         wb.core_addr     <= '0;
         wb.core_data_out <= '0;
         ahb.hrdata       <= '0;
         ahb.hexokay      <= 1'b0;
         addr_q           <= '0;
         size_q           <= '0;
         excl_q           <= 1'b0;
         wdata_q          <= '0;
         old_q            <= '0;
         resv_v           <= 1'b0;
         resv_a           <= '0;
         excl_pass        <= 1'b0;
         cnt              <= '0;
      end else begin
         wb.core_cyc      <= cyc_d;
         wb.core_stb      <= stb_d;
         wb.core_we       <= we_d;
         wb.core_sel      <= sel_d;
         wb.core_data_out <= dout_d;
         ahb.hexokay      <= (state == ST_WRITE) && ack_v && excl_pass;

         if (accept) begin
            addr_q       <= ahb.haddr;
            size_q       <= ahb.hsize;
            excl_q       <= ahb.hexcl;
            wb.core_addr <= {ahb.haddr[31:2], 2'b00};
         end

         // Reservation is dropped by any exclusive store or any store to it
         if (state == ST_WDATA) begin
            wdata_q   <= ahb.hwdata;
            excl_pass <= excl_q && resv_hit;
            if (excl_q || resv_hit) resv_v <= 1'b0;
         end

         if (state == ST_READ && ack_v) begin
            ahb.hrdata <= wb.core_data_in;
            if (excl_q) begin
               resv_v <= 1'b1;
               resv_a <= addr_q[31:2];
            end
         end

         if (state == ST_RMW_READ && ack_v) old_q <= wb.core_data_in;

         if (stb_d && !wb.core_stb) cnt <= '0;
         else if (wb.core_stb)      cnt <= cnt + 1'b1;
         else                       cnt <= '0;
      end
   end

endmodule
